tcp_conn_demux: RTL and testbench
=================================

# tcp_conn_demux

Parametrised multi-connection receive steering stage that sits between the TCP header parser and the per-connection reorder buffers. It accepts one parsed segment at a time (metadata plus byte payload), matches the 4-tuple key against an `N_CONN`-entry connection table, and steers the payload to the matching channel or discards it. This generalises the single-connection receive path to `N_CONN` parallel connections, with optional passive-open slot allocation on SYN.

## Interface
- `N_CONN`, 4: number of connection slots and output channels (1..16).
- `CNT_W`, 16: width of the saturating drop counter.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `meta_valid` / `meta_ready` in / out, 1 / 1: segment metadata handshake.
- `meta_src_ip` in 32: remote IP address.
- `meta_src_port`, `meta_dst_port` in 16 each: remote and local ports.
- `meta_flags` in 8: TCP flags (bit1 SYN, bit2 RST, bit4 ACK).
- `meta_payload_len` in 16: payload bytes that follow on `s_axis`.
- `s_axis` slave `axi_stream_if`, 8-bit: segment payload.
- `m_tdata` out `N_CONN*8`: per-channel data, channel *i* at [8i+7:8i].
- `m_tvalid`, `m_tlast` out `N_CONN` each; `m_tready` in `N_CONN`.
- `hit_valid` out 1, `hit_chan` out `$clog2(N_CONN)`, `hit_flags` out 8: one-cycle pulse per matched segment, for the TCP control FSM.
- `tbl_wr` in 1, `tbl_idx` in `$clog2(N_CONN)`, `tbl_en` in 1, `tbl_ip` in 32, `tbl_rport` / `tbl_lport` in 16 each: table write port.
- `listen_port` in 16: local port accepted for passive open.
- `alloc_valid` out 1, `alloc_chan` out `$clog2(N_CONN)`: auto-allocation pulse.
- `drop_cnt` out `CNT_W`: saturating count of dropped segments.

## Operation
- States:
  - IDLE: `meta_ready=1`; on `meta_valid`, register the key, flags and length, then go to LOOKUP.
  - LOOKUP: one cycle; compare the key in parallel against all enabled entries.
    - Hit: the lowest matching index wins. Pulse `hit_*`. Go to FWD if length ≠ 0, else IDLE.
    - Miss: `drop_cnt` increments (saturates at all-ones). Go to DROP if length ≠ 0, else IDLE.
  - FWD: `s_axis.tready = m_tready[chan]`; data, valid and last routed to `chan` only; all other channels have `m_tvalid=0`. On an accepted `tlast`, go to IDLE.
  - DROP: `s_axis.tready=1`; discard beats until an accepted `tlast`, then go to IDLE.
- Length is informational only; `tlast` ends the segment. A `tlast` arriving early or late is not checked.
- Table write: `tbl_wr` updates entry `tbl_idx` on the next edge, in any state. A lookup in the same cycle sees the old contents. A write to the active channel during FWD does not redirect the current segment.
- If a `tbl_wr` and an auto-allocation (see Configuration) hit the same cycle, `tbl_wr` wins and the allocation is treated as no free slot (drop).

## Timing
- Reset values: all outputs 0 except `meta_ready=1`. All table entries are disabled, `drop_cnt=0`, state IDLE.
- Reset mid-segment: immediate return to IDLE. Remaining payload beats arrive with no segment context and are discarded via DROP only after a new metadata handshake; upstream must be reset together with this block.
- Metadata accepted at edge T. Lookup happens in cycle T+1; `hit_valid` / `alloc_valid` are high in cycle T+1. The first payload beat can be forwarded in cycle T+2 (combinational pass-through, zero added latency per beat).
- Throughput: one byte per cycle in FWD/DROP. The minimum gap between segments is 2 cycles (IDLE + LOOKUP).
- `m_tvalid` must not depend on `m_tready`.

## Configuration
- `TCP_DEMUX_AUTO_ALLOC_EN` defined:
  - Trigger: on a LOOKUP miss where SYN=1, ACK=0 and `meta_dst_port == listen_port`.
  - Allocation: the lowest disabled slot is written with the key (enabled) in cycle T+1. `alloc_valid` pulses with the index, and the segment is treated as a hit on that slot.
  - No free slot: drop.
  - Release: a matched segment with RST=1 disables its entry after `hit_valid`.
- Not defined: SYN misses are dropped like any miss, RST does not modify the table, `alloc_valid`/`alloc_chan` are tied to 0, and `listen_port` is unused.

## Structure
- `tcp_pkg` holds:
  - `tcp_conn_key_s` (ip, rport, lport);
  - `tcp_conn_entry_s` (en + key);
  - flag bit constants `TCP_FLAG_SYN`/`RST`/`ACK`;
  - the `tcp_demux_state_e` enum.
- Sub-module `tcp_conn_table`: `N_CONN` entry registers, write port, parallel compare, lowest-match and lowest-free priority encoders. The FSM and datapath muxing stay in the top.

## Test plan
- Entry 2 = {10.0.0.5, 5000, 80}; segment from 10.0.0.5:5000→80 with a 4-byte payload → `hit_chan=2`, 4 bytes on channel 2 only, `drop_cnt=0`.
- Same segment with `meta_src_port=5001` → no `m_tvalid` on any channel, 4 beats consumed, `drop_cnt=1`.
- Entries 1 and 3 hold the same key → delivered on channel 1 only.
- `m_tready[0]` toggling 1,0,0,1 during a 6-byte FWD → `s_axis.tready` mirrors it, all 6 bytes in order, `tlast` on the 6th.
- With `TCP_DEMUX_AUTO_ALLOC_EN`, empty table, `listen_port=80`, SYN to port 80 → `alloc_chan=0` and `hit_chan=0`. A following RST segment frees slot 0, so the next segment is dropped.
- `N_CONN=4` with all slots full, SYN miss → dropped. Also assert `rst_n` during byte 3 of FWD → all `m_tvalid=0`, `meta_ready=1` the next cycle.

Source files
------------

// File: rtl/tcp_pkg.sv
// -----------------------------------------------------------------------------
// tcp_pkg
// Shared types for the TCP receive steering stage: the connection 4-tuple
// key, connection table entry, TCP flag bit positions and the demux FSM
// state encoding. Also holds a helper that sizes channel-index ports so that
// a single-connection build still gets a 1-bit index.
// -----------------------------------------------------------------------------
package tcp_pkg;

    typedef struct packed {
        logic [31:0] ip;     // remote IP address
        logic [15:0] rport;  // remote port
        logic [15:0] lport;  // local port
    } tcp_conn_key_s;

    typedef struct packed {
        logic          en;
        tcp_conn_key_s key;
    } tcp_conn_entry_s;

    // Bit positions inside the 8-bit TCP flags byte. Three bits wide so
    // they index an 8-bit vector without width adjustment.
    localparam logic [2:0] TCP_FLAG_SYN = 3'd1;
    localparam logic [2:0] TCP_FLAG_RST = 3'd2;
    localparam logic [2:0] TCP_FLAG_ACK = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FWD,
        ST_DROP
    } tcp_demux_state_e;

    function automatic int tcp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// -----------------------------------------------------------------------------
// axi_stream_if
// Minimal AXI4-Stream bundle (tdata/tvalid/tready/tlast).
//   master modport : drives tdata, tvalid, tlast; samples tready
//   slave  modport : samples tdata, tvalid, tlast; drives tready
// -----------------------------------------------------------------------------
interface axi_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tcp_conn_table.sv
// -----------------------------------------------------------------------------
// tcp_conn_table
// N_CONN connection entries with one write port, parallel 4-tuple compare,
// and lowest-index priority encoders for the first match and the first
// disabled (free) slot.
//   i_wr_en/i_wr_idx/i_wr_entry : host table write (highest priority)
//   i_alloc_en/i_alloc_key      : write i_alloc_key, enabled, into o_free_idx
//   i_rel_en/i_rel_idx          : clear the enable bit of one entry
//   i_lk_key                    : key under lookup
//   o_lk_hit/o_lk_idx           : any match / lowest matching index
//   o_free_valid/o_free_idx     : any disabled slot / lowest disabled index
// Lookups see register contents, so a write in the same cycle is not visible
// until the following cycle.
// -----------------------------------------------------------------------------
module tcp_conn_table
    import tcp_pkg::*;
#(
    parameter int N_CONN = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  tcp_conn_entry_s  i_wr_entry,
    input  logic             i_alloc_en,
    input  tcp_conn_key_s    i_alloc_key,
    input  logic             i_rel_en,
    input  logic [IDX_W-1:0] i_rel_idx,
    input  tcp_conn_key_s    i_lk_key,
    output logic             o_lk_hit,
    output logic [IDX_W-1:0] o_lk_idx,
    output logic             o_free_valid,
    output logic [IDX_W-1:0] o_free_idx
);

    tcp_conn_entry_s   r_entry [N_CONN];
    logic [N_CONN-1:0] w_match;
    logic [N_CONN-1:0] w_free;

    always_comb begin
        for (int i = 0; i < N_CONN; i++) begin
            w_match[i] = r_entry[i].en && (r_entry[i].key == i_lk_key);
            w_free[i]  = !r_entry[i].en;
        end
    end

    assign o_lk_hit     = |w_match;
    assign o_free_valid = |w_free;

    // Scanning from the top down lets the lowest set index overwrite last.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    always_comb begin
        o_lk_idx   = '0;
        o_free_idx = '0;
        for (int i = N_CONN - 1; i >= 0; i--) begin
            if (w_match[i]) o_lk_idx   = IDX_W'(i);
            if (w_free[i])  o_free_idx = IDX_W'(i);
        end
    end

    // NOTE: the entries are reset even though they form a small memory: a
    // stale enable bit after reset would steer traffic to a dead connection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CONN; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CONN; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_entry[i] <= i_wr_entry;
                end else if (i_alloc_en && (o_free_idx == IDX_W'(i))) begin
                    r_entry[i] <= '{en: 1'b1, key: i_alloc_key};
                end else if (i_rel_en && (i_rel_idx == IDX_W'(i))) begin
                    r_entry[i].en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tcp_conn_demux.sv
// -----------------------------------------------------------------------------
// tcp_conn_demux
// Receive steering stage between the TCP header parser and the
// per-connection reorder buffers. One segment at a time: metadata is taken
// in IDLE, matched against the connection table in LOOKUP, then the payload
// is passed through combinationally to the matched channel (FWD) or
// swallowed (DROP) until tlast.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   meta_*                     : segment metadata handshake and fields
//   s_axis                     : 8-bit payload stream (slave)
//   m_tdata/m_tvalid/m_tlast   : per-channel payload out, channel i at
//   m_tready                     byte lane [8i+7:8i] / bit i
//   hit_valid/hit_chan/hit_flags : one-cycle pulse per matched segment
//   tbl_*                      : connection table write port
//   listen_port                : local port accepted for passive open
//   alloc_valid/alloc_chan     : auto-allocation pulse
//   drop_cnt                   : saturating dropped-segment count
//
// Build option
//   TCP_DEMUX_AUTO_ALLOC_EN : a SYN (no ACK) to listen_port that misses the
//   table claims the lowest disabled slot and is forwarded there; a matched
//   RST releases its slot. Without it, alloc_* are tied low and listen_port
//   is ignored.
// -----------------------------------------------------------------------------
module tcp_conn_demux
    import tcp_pkg::*;
#(
    parameter int N_CONN = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         meta_valid,
    output logic                         meta_ready,
    input  logic [31:0]                  meta_src_ip,
    input  logic [15:0]                  meta_src_port,
    input  logic [15:0]                  meta_dst_port,
    input  logic [7:0]                   meta_flags,
    input  logic [15:0]                  meta_payload_len,
    axi_stream_if.slave                  s_axis,
    output logic [N_CONN*8-1:0]          m_tdata,
    output logic [N_CONN-1:0]            m_tvalid,
    output logic [N_CONN-1:0]            m_tlast,
    input  logic [N_CONN-1:0]            m_tready,
    output logic                         hit_valid,
    output logic [tcp_idx_w(N_CONN)-1:0] hit_chan,
    output logic [7:0]                   hit_flags,
    input  logic                         tbl_wr,
    input  logic [tcp_idx_w(N_CONN)-1:0] tbl_idx,
    input  logic                         tbl_en,
    input  logic [31:0]                  tbl_ip,
    input  logic [15:0]                  tbl_rport,
    input  logic [15:0]                  tbl_lport,
    input  logic [15:0]                  listen_port,
    output logic                         alloc_valid,
    output logic [tcp_idx_w(N_CONN)-1:0] alloc_chan,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int IDX_W = tcp_idx_w(N_CONN);

    tcp_demux_state_e r_state;
    tcp_demux_state_e w_next_state;
    tcp_conn_key_s    r_key;
    logic [7:0]       r_flags;
    logic [15:0]      r_len;
    logic [IDX_W-1:0] r_chan;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_lk_hit;
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_free_valid;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_alloc;
    logic             w_release;
    logic             w_hit;
    logic [IDX_W-1:0] w_chan;
    logic             w_sel_ready;
    logic             w_s_tready;
    tcp_conn_entry_s  w_wr_entry;

    assign w_wr_entry = '{en: tbl_en,
                          key: '{ip: tbl_ip, rport: tbl_rport, lport: tbl_lport}};

`ifdef TCP_DEMUX_AUTO_ALLOC_EN
    logic w_syn_open;

    assign w_syn_open = r_flags[TCP_FLAG_SYN] && !r_flags[TCP_FLAG_ACK]
                        && (r_key.lport == listen_port);
    // A host table write in the same cycle owns the write port, so the SYN
    // is handled as if no slot were free.
    assign w_alloc     = (r_state == ST_LOOKUP) && !w_lk_hit && w_syn_open
                         && w_free_valid && !tbl_wr;
    assign w_release   = (r_state == ST_LOOKUP) && w_lk_hit && r_flags[TCP_FLAG_RST];
    assign alloc_valid = w_alloc;
    assign alloc_chan  = w_alloc ? w_free_idx : '0;
`else
    logic w_unused;

    assign w_alloc     = 1'b0;
    assign w_release   = 1'b0;
    assign alloc_valid = 1'b0;
    assign alloc_chan  = '0;
    assign w_unused    = ^{listen_port, w_free_valid, w_free_idx};
`endif

    tcp_conn_table #(
        .N_CONN (N_CONN),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (tbl_wr),
        .i_wr_idx     (tbl_idx),
        .i_wr_entry   (w_wr_entry),
        .i_alloc_en   (w_alloc),
        .i_alloc_key  (r_key),
        .i_rel_en     (w_release),
        .i_rel_idx    (w_lk_idx),
        .i_lk_key     (r_key),
        .o_lk_hit     (w_lk_hit),
        .o_lk_idx     (w_lk_idx),
        .o_free_valid (w_free_valid),
        .o_free_idx   (w_free_idx)
    );

    // An allocated slot behaves exactly like a table hit on that slot.
    assign w_hit  = w_lk_hit || w_alloc;
    assign w_chan = w_lk_hit ? w_lk_idx : w_free_idx;

    assign hit_valid = (r_state == ST_LOOKUP) && w_hit;
    assign hit_chan  = hit_valid ? w_chan : '0;
    assign hit_flags = hit_valid ? r_flags : '0;
    assign drop_cnt  = r_drop_cnt;

    // Ready of the currently selected channel; r_chan is held for the whole
    // segment so a table rewrite cannot redirect it mid-flight.
    always_comb begin
        w_sel_ready = 1'b0;
        for (int i = 0; i < N_CONN; i++) begin
            if (r_chan == IDX_W'(i)) w_sel_ready = m_tready[i];
        end
    end

    // Output routing uses only tvalid/tlast/tdata, never m_tready.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = '0;
        m_tlast  = '0;
        for (int i = 0; i < N_CONN; i++) begin
            if ((r_state == ST_FWD) && (r_chan == IDX_W'(i))) begin
                m_tdata[i*8 +: 8] = s_axis.tdata;
                m_tvalid[i]       = s_axis.tvalid;
                m_tlast[i]        = s_axis.tlast;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        meta_ready   = 1'b0;
        w_s_tready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                meta_ready = 1'b1;
                if (meta_valid) w_next_state = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (r_len != '0) w_next_state = w_hit ? ST_FWD : ST_DROP;
                else             w_next_state = ST_IDLE;
            end
            ST_FWD: begin
                w_s_tready = w_sel_ready;
                if (s_axis.tvalid && w_sel_ready && s_axis.tlast) w_next_state = ST_IDLE;
            end
            ST_DROP: begin
                w_s_tready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign s_axis.tready = w_s_tready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key      <= '0;
            r_flags    <= '0;
            r_len      <= '0;
            r_chan     <= '0;
            r_drop_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && meta_valid) begin
                r_key   <= '{ip: meta_src_ip, rport: meta_src_port, lport: meta_dst_port};
                r_flags <= meta_flags;
                r_len   <= meta_payload_len;
            end
            if (r_state == ST_LOOKUP) begin
                if (w_hit) begin
                    r_chan <= w_chan;
                end else if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tcp_conn_demux.sv
module tb_tcp_conn_demux;
    import tcp_pkg::*;

    localparam int N_CONN  = 4;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef TCP_DEMUX_AUTO_ALLOC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [7:0]  F_SYN = 8'h02;
    localparam logic [7:0]  F_RST = 8'h04;
    localparam logic [7:0]  F_ACK = 8'h10;
    localparam logic [31:0] IP5   = 32'h0A00_0005;
    localparam logic [31:0] IP6   = 32'h0A00_0006;
    localparam logic [31:0] IP7   = 32'h0A00_0007;
    localparam logic [31:0] IP8   = 32'h0A00_0008;
    localparam logic [31:0] IP9   = 32'h0A00_0009;

    logic                clk;
    logic                rst_n;
    logic                meta_valid;
    logic                meta_ready;
    logic [31:0]         meta_src_ip;
    logic [15:0]         meta_src_port;
    logic [15:0]         meta_dst_port;
    logic [7:0]          meta_flags;
    logic [15:0]         meta_payload_len;
    logic [N_CONN*8-1:0] m_tdata;
    logic [N_CONN-1:0]   m_tvalid;
    logic [N_CONN-1:0]   m_tlast;
    logic [N_CONN-1:0]   m_tready;
    logic                hit_valid;
    logic [IDX_W-1:0]    hit_chan;
    logic [7:0]          hit_flags;
    logic                tbl_wr;
    logic [IDX_W-1:0]    tbl_idx;
    logic                tbl_en;
    logic [31:0]         tbl_ip;
    logic [15:0]         tbl_rport;
    logic [15:0]         tbl_lport;
    logic [15:0]         listen_port;
    logic                alloc_valid;
    logic [IDX_W-1:0]    alloc_chan;
    logic [CNT_W-1:0]    drop_cnt;

    axi_stream_if #(.DATA_W(8)) s_axis_if ();

    tcp_conn_demux #(.N_CONN(N_CONN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .meta_valid       (meta_valid),
        .meta_ready       (meta_ready),
        .meta_src_ip      (meta_src_ip),
        .meta_src_port    (meta_src_port),
        .meta_dst_port    (meta_dst_port),
        .meta_flags       (meta_flags),
        .meta_payload_len (meta_payload_len),
        .s_axis           (s_axis_if),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tlast          (m_tlast),
        .m_tready         (m_tready),
        .hit_valid        (hit_valid),
        .hit_chan         (hit_chan),
        .hit_flags        (hit_flags),
        .tbl_wr           (tbl_wr),
        .tbl_idx          (tbl_idx),
        .tbl_en           (tbl_en),
        .tbl_ip           (tbl_ip),
        .tbl_rport        (tbl_rport),
        .tbl_lport        (tbl_lport),
        .listen_port      (listen_port),
        .alloc_valid      (alloc_valid),
        .alloc_chan       (alloc_chan),
        .drop_cnt         (drop_cnt)
    );

    typedef struct {
        int         chan;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         chan;
        logic [7:0] flags;
    } hit_t;

    typedef struct {
        logic [31:0] ip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [7:0]  flags;
        int          len;
        bit          hit;
        int          chan;
    } vec_t;

    beat_t beat_q[$];
    hit_t  hit_q[$];
    int    alloc_q[$];
    int    n_pass   = 0;
    int    n_total  = 0;
    int    exp_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard side: compares DUT output events against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hit_valid) begin
                if (hit_q.size() == 0) begin
                    check("hit_unexpected", hit_valid, 0);
                end else begin
                    check("hit_chan", hit_chan, hit_q[0].chan);
                    check("hit_flags", hit_flags, hit_q[0].flags);
                    void'(hit_q.pop_front());
                end
            end
            if (alloc_valid) begin
                if (alloc_q.size() == 0) begin
                    check("alloc_unexpected", alloc_valid, 0);
                end else begin
                    check("alloc_chan", alloc_chan, alloc_q[0]);
                    void'(alloc_q.pop_front());
                end
            end
            for (int i = 0; i < N_CONN; i++) begin
                if (m_tvalid[i]) begin
                    if (beat_q.size() == 0) begin
                        check("beat_unexpected", m_tvalid[i], 0);
                    end else begin
                        check("beat_chan", i, beat_q[0].chan);
                        if (m_tready[i]) begin
                            check("beat_data", m_tdata[i*8 +: 8], beat_q[0].data);
                            check("beat_last", m_tlast[i], beat_q[0].last);
                            void'(beat_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input logic [IDX_W-1:0] idx, input logic en, input logic [31:0] ip,
                             input logic [15:0] rp, input logic [15:0] lp);
        tbl_wr = 1'b1; tbl_idx = idx; tbl_en = en; tbl_ip = ip; tbl_rport = rp; tbl_lport = lp;
        @(posedge clk);
        #1;
        tbl_wr = 1'b0;
    endtask

    // Returns at posedge+1 of the LOOKUP cycle.
    task automatic send_meta(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                             input logic [7:0] flags, input int len);
        bit ok;
        meta_src_ip = ip; meta_src_port = sp; meta_dst_port = dp;
        meta_flags = flags; meta_payload_len = 16'(len);
        meta_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = meta_ready;
            @(posedge clk);
            #1;
        end
        meta_valid = 1'b0;
        if (!ok) check("meta_timeout", 0, 1);
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic last, output bit ok);
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = d;
        s_axis_if.tlast  = last;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            ok = s_axis_if.tready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("beat_timeout", 0, 1);
    endtask

    task automatic send_payload(input int len, input bit fwd, input int chan, output int acc);
        logic [7:0] d;
        bit         ok;
        acc = 0;
        for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            if (fwd) beat_q.push_back('{chan: chan, data: d, last: (b == len - 1)});
            drive_beat(d, (b == len - 1), ok);
            if (!ok) break;
            acc++;
        end
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
    endtask

    task automatic expect_seg(input bit hit, input int chan, input logic [7:0] flags);
        if (hit) hit_q.push_back('{chan: chan, flags: flags});
        else if (exp_drop < CNT_MAX) exp_drop++;
    endtask

    task automatic settle_checks();
        idle(2);
        check("drop_cnt", drop_cnt, exp_drop);
        check("hit_q_empty", hit_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);
        check("alloc_q_empty", alloc_q.size(), 0);
    endtask

    task automatic run_seg(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                           input logic [7:0] flags, input int len, input bit hit, input int chan);
        int acc;
        expect_seg(hit, chan, flags);
        send_meta(ip, sp, dp, flags, len);
        send_payload(len, hit, chan, acc);
        check("beats_consumed", acc, len);
        settle_checks();
    endtask

    vec_t        vecs [8];
    logic [7:0]  tog_data [6];
    logic [3:0]  pat;
    bit          ok;
    int          nb;
    int          nc;

    initial begin
        rst_n = 1'b0; meta_valid = 1'b0; meta_src_ip = '0; meta_src_port = '0;
        meta_dst_port = '0; meta_flags = '0; meta_payload_len = '0;
        s_axis_if.tvalid = 1'b0; s_axis_if.tdata = '0; s_axis_if.tlast = 1'b0;
        m_tready = '1; tbl_wr = 1'b0; tbl_idx = '0; tbl_en = 1'b0; tbl_ip = '0;
        tbl_rport = '0; tbl_lport = '0; listen_port = '0;

        // Reset state
        idle(3);
        check("rst_meta_ready", meta_ready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_alloc_valid", alloc_valid, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_s_tready", s_axis_if.tready, 0);
        rst_n = 1'b1;
        idle(1);

        // Table: entry 2 = 10.0.0.5:5000->80, entries 1 and 3 share a key,
        // entry 0 written but disabled.
        tbl_write(2, 1'b1, IP5, 16'd5000, 16'd80);
        tbl_write(1, 1'b1, IP9, 16'd6000, 16'd443);
        tbl_write(3, 1'b1, IP9, 16'd6000, 16'd443);
        tbl_write(0, 1'b0, IP7, 16'd7000, 16'd22);

        vecs[0] = '{IP5, 16'd5000, 16'd80,  F_ACK, 4, 1'b1, 2};
        vecs[1] = '{IP5, 16'd5001, 16'd80,  F_ACK, 4, 1'b0, 0};
        vecs[2] = '{IP9, 16'd6000, 16'd443, F_ACK, 3, 1'b1, 1};
        vecs[3] = '{IP7, 16'd7000, 16'd22,  F_ACK, 2, 1'b0, 0};
        vecs[4] = '{IP5, 16'd5000, 16'd80,  F_ACK | F_RST, 0, 1'b1, 2};
        vecs[5] = '{IP5, 16'd5000, 16'd81,  F_ACK, 0, 1'b0, 0};
        vecs[6] = '{IP6, 16'd5000, 16'd80,  F_ACK, 1, 1'b0, 0};
        vecs[7] = '{IP9, 16'd6000, 16'd443, 8'h18, 5, 1'b1, 1};
        for (int v = 0; v < 8; v++) begin
            run_seg(vecs[v].ip, vecs[v].sp, vecs[v].dp, vecs[v].flags,
                    vecs[v].len, vecs[v].hit, vecs[v].chan);
        end
        // RST on a hit must not release slot 2 without auto-alloc; with it,
        // slot 2 was released by vecs[4], so re-arm before relying on it.
        tbl_write(2, 1'b1, IP5, 16'd5000, 16'd80);

        // Table write in the LOOKUP cycle is not seen by that lookup.
        expect_seg(1'b0, 0, F_ACK);
        send_meta(IP7, 16'd7000, 16'd22, F_ACK, 0);
        tbl_write(0, 1'b1, IP7, 16'd7000, 16'd22);
        settle_checks();
        run_seg(IP7, 16'd7000, 16'd22, F_ACK, 2, 1'b1, 0);

        // Backpressure on channel 0: m_tready[0] = 1,0,0,1 then 1.
        pat = 4'b1001;
        expect_seg(1'b1, 0, F_ACK);
        for (int b = 0; b < 6; b++) begin
            tog_data[b] = 8'($urandom);
            beat_q.push_back('{chan: 0, data: tog_data[b], last: (b == 5)});
        end
        send_meta(IP7, 16'd7000, 16'd22, F_ACK, 6);
        idle(1);
        nb = 0;
        nc = 0;
        while (nb < 6 && nc < 40) begin
            m_tready[0]      = (nc < 4) ? pat[nc] : 1'b1;
            s_axis_if.tvalid = 1'b1;
            s_axis_if.tdata  = tog_data[nb];
            s_axis_if.tlast  = (nb == 5);
            @(negedge clk);
            check("tready_mirror", s_axis_if.tready, m_tready[0]);
            ok = s_axis_if.tready;
            @(posedge clk);
            #1;
            if (ok) nb++;
            nc++;
        end
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        m_tready[0]      = 1'b1;
        check("toggle_beats", nb, 6);
        settle_checks();

        // All four slots enabled: SYN to the listen port has nowhere to go.
        listen_port = 16'd80;
        run_seg(IP8, 16'd4000, 16'd80, F_SYN, 3, 1'b0, 0);

        // Drop counter saturation.
        for (int k = 0; k < 12; k++) begin
            run_seg(IP6, 16'(k), 16'd9, F_ACK, 0, 1'b0, 0);
        end

        // Reset while byte 3 of a 6-byte forward is on the bus.
        expect_seg(1'b1, 2, F_ACK);
        send_meta(IP5, 16'd5000, 16'd80, F_ACK, 6);
        for (int b = 0; b < 2; b++) begin
            tog_data[b] = 8'($urandom);
            beat_q.push_back('{chan: 2, data: tog_data[b], last: 1'b0});
            drive_beat(tog_data[b], 1'b0, ok);
        end
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = 8'hA5;
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_meta_ready", meta_ready, 1);
        idle(1);
        check("midrst_m_tvalid_next", m_tvalid, 0);
        check("midrst_meta_ready_next", meta_ready, 1);
        check("midrst_drop_cnt", drop_cnt, 0);
        s_axis_if.tvalid = 1'b0;
        rst_n = 1'b1;
        exp_drop = 0;
        idle(1);
        check("midrst_beat_q", beat_q.size(), 0);

        // Passive open on an empty table, then RST release.
        listen_port = 16'd80;
        if (AUTO) alloc_q.push_back(0);
        run_seg(IP5, 16'd5000, 16'd80, F_SYN, 0, AUTO, 0);
        run_seg(IP5, 16'd5000, 16'd80, F_RST | F_ACK, 0, AUTO, 0);
        run_seg(IP5, 16'd5000, 16'd80, F_ACK, 2, 1'b0, 0);
        run_seg(IP5, 16'd5000, 16'd80, F_SYN | F_ACK, 1, 1'b0, 0);
        run_seg(IP5, 16'd5000, 16'd81, F_SYN, 1, 1'b0, 0);

        // Host write in the same cycle as a would-be allocation wins.
        expect_seg(1'b0, 0, F_SYN);
        send_meta(IP8, 16'd4000, 16'd80, F_SYN, 0);
        tbl_write(3, 1'b0, IP6, 16'd1, 16'd1);
        settle_checks();

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
